// File: rtl/boot_copier.sv
// boot_copier: copies boot ROM words into RAM, holding the CPU in reset until done (ports: I_clk, I_reset_n, I_start; ROM O_rom_enable/O_rom_addr/I_rom_data; RAM O_ram_we/O_ram_addr/O_ram_data/I_ram_ready; status O_busy/O_done/O_cpu_hold)
module boot_copier #(
  parameter int          ROM_BYTES = 256,
  parameter logic [15:0] RAM_BASE  = 16'h0000
) (
  input  logic        I_clk,
  input  logic        I_reset_n,
  input  logic        I_start,
  output logic        O_rom_enable,
  output logic [7:0]  O_rom_addr,
  input  logic [15:0] I_rom_data,
  output logic        O_ram_we,
  output logic [15:0] O_ram_addr,
  output logic [15:0] O_ram_data,
  input  logic        I_ram_ready,
  output logic        O_busy,
  output logic        O_done,
  output logic        O_cpu_hold
);
  localparam int WORDS = ROM_BYTES / 2;
  typedef enum logic [2:0] {IDLE, READ, CAPTURE, WRITE, DONE} state_t;
  state_t     state;
  logic [6:0] k;
  always_ff @(posedge I_clk) begin
    if (!I_reset_n) begin
      state        <= IDLE;
      k            <= '0;
      O_rom_enable <= 1'b0;
      O_rom_addr   <= 8'h00;
      O_ram_we     <= 1'b0;
      O_ram_addr   <= RAM_BASE;
      O_ram_data   <= 16'h0000;
      O_busy       <= 1'b0;
      O_done       <= 1'b0;
      O_cpu_hold   <= 1'b1;
    end else begin
      case (state)
        IDLE: if (I_start) begin
          state        <= READ;
          k            <= '0;
          O_rom_enable <= 1'b1;
          O_rom_addr   <= 8'h00;
          O_busy       <= 1'b1;
        end
        READ: begin
          state        <= CAPTURE;
          O_rom_enable <= 1'b0;
          O_ram_addr   <= RAM_BASE + {9'd0, k};
        end
        CAPTURE: begin
          state      <= WRITE;
          O_ram_data <= I_rom_data;
          O_ram_we   <= 1'b1;
        end
        WRITE: if (I_ram_ready) begin
          O_ram_we <= 1'b0;
          if (k == 7'(WORDS - 1)) begin
            state      <= DONE;
            O_busy     <= 1'b0;
            O_done     <= 1'b1;
            O_cpu_hold <= 1'b0;
          end else begin
            state        <= READ;
            k            <= k + 7'd1;
            O_rom_enable <= 1'b1;
            O_rom_addr   <= {k + 7'd1, 1'b0};
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_boot_copier.sv
// tb_boot_copier: randomized self-checking bench for boot_copier against a word-list reference model
module tb_boot_copier;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  st, rdy, ren, we, busy, done, hold;
  logic [7:0]  raddr[2];
  logic [15:0] rdata[2], waddr[2], wdata[2];
  logic [7:0]  mem[256];
  int          errs = 0, checks = 0, t;
  always #5 clk = ~clk;
  boot_copier dut0 (
    .I_clk(clk), .I_reset_n(rst_n), .I_start(st[0]),
    .O_rom_enable(ren[0]), .O_rom_addr(raddr[0]), .I_rom_data(rdata[0]),
    .O_ram_we(we[0]), .O_ram_addr(waddr[0]), .O_ram_data(wdata[0]), .I_ram_ready(rdy[0]),
    .O_busy(busy[0]), .O_done(done[0]), .O_cpu_hold(hold[0])
  );
  boot_copier #(.ROM_BYTES(8), .RAM_BASE(16'hFFFE)) dut1 (
    .I_clk(clk), .I_reset_n(rst_n), .I_start(st[1]),
    .O_rom_enable(ren[1]), .O_rom_addr(raddr[1]), .I_rom_data(rdata[1]),
    .O_ram_we(we[1]), .O_ram_addr(waddr[1]), .O_ram_data(wdata[1]), .I_ram_ready(rdy[1]),
    .O_busy(busy[1]), .O_done(done[1]), .O_cpu_hold(hold[1])
  );
  always @(posedge clk) begin
    if (ren[0]) rdata[0] <= {mem[8'(raddr[0] + 8'd1)], mem[raddr[0]]};
    if (ren[1]) rdata[1] <= {mem[8'(raddr[1] + 8'd1)], mem[raddr[1]]};
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic rst_chk();
    chk("rst_rom", {23'd0, ren[0], raddr[0]}, 32'd0);
    chk("rst_ram", {we[0], waddr[0], wdata[0]}, 32'd0);
    chk("rst_stat", {busy[0], done[0], hold[0]}, 32'b001);
    chk("rst_dut1", {we[1], ren[1], busy[1], done[1], hold[1], waddr[1]}, {5'b00001, 16'hFFFE});
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_chk();
    rst_n = 1'b1;
  endtask
  // mode: 0 ready high, 1 random ready, 2 backpressure on word 3, 3 abort after word 10, 4 random ready + start noise
  task automatic copy(input bit s, input int mode, output int tt);
    int          w = s ? 4 : 128;
    logic [15:0] base = s ? 16'hFFFE : 16'h0000;
    int          idx = 0, stalls = 0, low = 0, run = 0;
    bit          fin = 0;
    st[s] = 1'b1;
    rdy[s] = 1'b1;
    @(negedge clk);
    st[s] = 1'b0;
    tt = 0;
    while (!fin && tt < 4000) begin
      if (done[s]) begin
        fin = 1;
        chk("done_time", tt, 3 * w + stalls);
        chk("done_outs", {ren[s], we[s], busy[s], hold[s]}, 32'd0);
      end else begin
        chk("busy_hold", {busy[s], hold[s], we[s] & ren[s]}, 32'b110);
        if (mode == 3 && idx == 11) return;
        rdy[s] = (mode == 1 || mode == 4) ? ($urandom_range(0, 3) != 0) :
                 (mode == 2) ? !(we[s] && waddr[s] == 16'd3 && low < 5) : 1'b1;
        if (mode == 4) st[s] = 1'($urandom_range(0, 1));
        if (!rdy[s]) low++;
        if (mode == 2 && we[s] && waddr[s] == 16'd3) begin
          run++;
          chk("bp_hold", {waddr[s], wdata[s]}, {16'd3, 16'h0706});
        end
        if (we[s] && !rdy[s]) stalls++;
        if (we[s] && rdy[s]) begin
          chk("wr_addr", waddr[s], 16'(base + 16'(idx)));
          chk("wr_data", wdata[s], {mem[2 * idx + 1], mem[2 * idx]});
          idx++;
        end
        @(negedge clk);
        tt++;
      end
    end
    st[s] = 1'b0;
    chk("finished", fin, 1);
    chk("nwords", idx, w);
    if (mode == 2) chk("bp_we_cycles", run, 6);
    st[s] = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("done_sticky", {done[s], we[s], ren[s], busy[s], hold[s]}, 32'b10000);
    end
    st[s] = 1'b0;
  endtask
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    rst_n = 1'b0;
    st = 2'b11;
    rdy = 2'b11;
    repeat (2) begin
      @(negedge clk);
      rst_chk();
    end
    st = 2'b00;
    rst_n = 1'b1;
    @(negedge clk);
    copy(0, 0, t);
    chk("full_total", t, 384);
    do_reset();
    copy(0, 2, t);
    chk("bp_total", t, 389);
    do_reset();
    copy(0, 3, t);
    rst_n = 1'b0;
    @(negedge clk);
    rst_chk();
    rst_n = 1'b1;
    copy(0, 0, t);
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    do_reset();
    copy(0, 1, t);
    do_reset();
    copy(0, 4, t);
    do_reset();
    copy(1, 0, t);
    chk("wrap_total", t, 12);
    do_reset();
    copy(1, 1, t);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
